// File: rtl/imem_sync.sv
// Synchronous instruction memory for the pipelined LEGv8 core: one-cycle registered fetch with
// stall hold, a runtime programming port, and a NOP self-initialisation sweep after reset.
module imem_sync #(
   parameter int                DEPTH  = 48,
   parameter int                ADDR_W = 6,
   parameter int                DATA_W = 32,
   parameter logic [DATA_W-1:0] NOP    = 32'hD503201F
) (
   input  logic              clk,
   input  logic              reset,
   output logic              ready,
   input  logic              fetch_valid,
   input  logic              stall,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] q,
   output logic              q_valid,
   output logic              oob,
   input  logic              prog_en,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic              prog_err
);

   localparam int                IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int                CNT_W = $clog2(DEPTH) + 1;
   localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DEPTH - 1);

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_next;
   logic               we;
   logic [IDX_W-1:0]   wa;
   logic [DATA_W-1:0]  wd;
   logic               fetch_hit;
   logic               prog_hit;
   logic [DATA_W-1:0]  mem [DEPTH];

   // Range checks are widened by one bit so DEPTH == 2**ADDR_W compares correctly.
   assign fetch_hit = {1'b0, addr} < LIMIT;
   assign prog_hit  = {1'b0, prog_addr} < LIMIT;
   assign ready     = (state == RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Single write port shared between the init sweep and the programming port.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      we         = 1'b0;
      wa         = '0;
      wd         = prog_data;
      case (state)
         INIT: begin
            we       = !reset;
            wa       = cnt[IDX_W-1:0];
            wd       = NOP;
            cnt_next = cnt + CNT_W'(1);
            if (cnt == LAST) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (prog_en && prog_hit) begin
               we = !reset;
               wa = prog_addr[IDX_W-1:0];
            end
         end
         default: begin
            state_next = INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wa] <= wd;
      end
   end

   // Non-blocking read of mem gives read-before-write on a same-address collision.
   always_ff @(posedge clk) begin
      if (reset || state == INIT) begin
         q       <= NOP;
         q_valid <= 1'b0;
         oob     <= 1'b0;
      end else if (!stall) begin
         if (fetch_valid && fetch_hit) begin
            q       <= mem[addr[IDX_W-1:0]];
            q_valid <= 1'b1;
            oob     <= 1'b0;
         end else if (fetch_valid) begin
            q       <= NOP;
            q_valid <= 1'b1;
            oob     <= 1'b1;
         end else begin
            q       <= NOP;
            q_valid <= 1'b0;
            oob     <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prog_err <= 1'b0;
      end else if (state == INIT) begin
         prog_err <= prog_en;
      end else begin
         prog_err <= prog_en && !prog_hit;
      end
   end

endmodule

// File: tb/tb_imem_sync.sv
// Self-checking bench for imem_sync: directed scenarios plus randomized traffic, checked
// against an array-based reference memory that tracks the init sweep by a countdown.
module tb_imem_sync;

   localparam int          DEPTH  = 48;
   localparam int          ADDR_W = 6;
   localparam int          DATA_W = 32;
   localparam logic [31:0] NOP    = 32'hD503201F;

   logic              clk = 1'b0;
   logic              reset;
   logic              ready;
   logic              fetch_valid;
   logic              stall;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] q;
   logic              q_valid;
   logic              oob;
   logic              prog_en;
   logic [ADDR_W-1:0] prog_addr;
   logic [DATA_W-1:0] prog_data;
   logic              prog_err;

   imem_sync #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .NOP   (NOP)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ready      (ready),
      .fetch_valid(fetch_valid),
      .stall      (stall),
      .addr       (addr),
      .q          (q),
      .q_valid    (q_valid),
      .oob        (oob),
      .prog_en    (prog_en),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .prog_err   (prog_err)
   );

   always #5 clk = ~clk;

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [31:0] model_mem [DEPTH];
   int          init_left;
   bit          model_ready;
   logic [31:0] exp_q;
   logic        exp_valid;
   logic        exp_oob;
   logic        exp_err;

   task automatic checkOutput(input string tag);
      tests_run++;
      assert (q === exp_q) else begin
         tests_failed++;
         $error("[TB] FAIL %s q: observed %h expected %h", tag, q, exp_q);
      end
      tests_run++;
      assert (q_valid === exp_valid) else begin
         tests_failed++;
         $error("[TB] FAIL %s q_valid: observed %b expected %b", tag, q_valid, exp_valid);
      end
      tests_run++;
      assert (oob === exp_oob) else begin
         tests_failed++;
         $error("[TB] FAIL %s oob: observed %b expected %b", tag, oob, exp_oob);
      end
      tests_run++;
      assert (prog_err === exp_err) else begin
         tests_failed++;
         $error("[TB] FAIL %s prog_err: observed %b expected %b", tag, prog_err, exp_err);
      end
      tests_run++;
      assert (ready === model_ready) else begin
         tests_failed++;
         $error("[TB] FAIL %s ready: observed %b expected %b", tag, ready, model_ready);
      end
   endtask

   task automatic checkWord(input string tag, input logic [31:0] expected);
      tests_run++;
      assert (q === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s q: observed %h expected %h", tag, q, expected);
      end
   endtask

   // Holds reset for n edges; after release every word is expected to read NOP once swept.
   task automatic doReset(input int n);
      reset       = 1'b1;
      fetch_valid = 1'b0;
      stall       = 1'b0;
      addr        = '0;
      prog_en     = 1'b0;
      prog_addr   = '0;
      prog_data   = '0;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
      init_left   = DEPTH;
      model_ready = 1'b0;
      exp_q       = NOP;
      exp_valid   = 1'b0;
      exp_oob     = 1'b0;
      exp_err     = 1'b0;
      checkOutput("reset");
   endtask

   // Drives one cycle of inputs, advances the reference model, and waits past the edge.
   task automatic applyStimulus(input logic fv, input logic st, input logic [ADDR_W-1:0] a,
                                input logic pe, input logic [ADDR_W-1:0] pa,
                                input logic [31:0] pd);
      bit was_ready;
      fetch_valid = fv;
      stall       = st;
      addr        = a;
      prog_en     = pe;
      prog_addr   = pa;
      prog_data   = pd;
      was_ready   = model_ready;
      if (!was_ready) begin
         exp_q     = NOP;
         exp_valid = 1'b0;
         exp_oob   = 1'b0;
         exp_err   = pe;
         init_left = init_left - 1;
         if (init_left == 0) model_ready = 1'b1;
      end else begin
         if (!st) begin
            if (!fv) begin
               exp_q = NOP; exp_valid = 1'b0; exp_oob = 1'b0;
            end else if (int'(a) >= DEPTH) begin
               exp_q = NOP; exp_valid = 1'b1; exp_oob = 1'b1;
            end else begin
               exp_q = model_mem[int'(a)]; exp_valid = 1'b1; exp_oob = 1'b0;
            end
         end
         exp_err = pe && (int'(pa) >= DEPTH);
         if (pe && int'(pa) < DEPTH) model_mem[int'(pa)] = pd;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idleSweep(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         applyStimulus(1'(i % 2), 1'b0, ADDR_W'(i), 1'(i % 5 == 0), ADDR_W'(i), 32'hDEAD0000 + i);
         checkOutput(tag);
      end
   endtask

   task automatic fetchAll(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, 1'b0, ADDR_W'(i), 1'b0, '0, '0);
         checkOutput(tag);
         checkWord(tag, NOP);
      end
   endtask

   initial begin
      fetch_valid = 1'b0;
      stall       = 1'b0;
      addr        = '0;
      prog_en     = 1'b0;
      prog_addr   = '0;
      prog_data   = '0;

      // Scenario 1: one-cycle reset, sweep of DEPTH cycles, then all words read NOP.
      doReset(1);
      idleSweep("init_sweep", DEPTH);
      fetchAll("init_readback");

      // Scenario 2: program then fetch.
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 6'd5, 32'h91002001);
      checkOutput("prog5");
      applyStimulus(1'b1, 1'b0, 6'd5, 1'b0, '0, '0);
      checkOutput("fetch5");
      checkWord("fetch5_lit", 32'h91002001);

      // Scenario 3: out-of-range fetch and rejected write.
      applyStimulus(1'b1, 1'b0, 6'd50, 1'b1, 6'd63, 32'h12345678);
      checkOutput("oob_fetch_prog63");
      applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0);
      checkOutput("prog_err_clears");
      applyStimulus(1'b1, 1'b0, 6'd63, 1'b0, '0, '0);
      checkOutput("fetch63");

      // Scenario 4: stall holds q while addr moves on.
      applyStimulus(1'b1, 1'b0, 6'd5, 1'b0, '0, '0);
      checkOutput("prestall");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 6'd6, 1'b0, '0, '0);
         checkOutput("stall_hold");
         checkWord("stall_lit", 32'h91002001);
      end
      applyStimulus(1'b1, 1'b0, 6'd6, 1'b0, '0, '0);
      checkOutput("stall_release");

      // Scenario 5: same-cycle read and write of one address returns the old word.
      applyStimulus(1'b1, 1'b0, 6'd7, 1'b1, 6'd7, 32'h8B010021);
      checkOutput("rbw_old");
      checkWord("rbw_old_lit", NOP);
      applyStimulus(1'b1, 1'b0, 6'd7, 1'b0, '0, '0);
      checkOutput("rbw_new");
      checkWord("rbw_new_lit", 32'h8B010021);

      // Scenario 6: reset mid-sweep and again mid-run after programming.
      doReset(1);
      idleSweep("sweep_part", 20);
      doReset(1);
      idleSweep("sweep_restart", DEPTH);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 6'd3, 32'hCAFEF00D);
      checkOutput("prog3");
      doReset(2);
      idleSweep("sweep_after_run", DEPTH);
      fetchAll("post_reset_readback");

      // Randomized traffic against the reference memory.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                       ADDR_W'($urandom_range(0, 63)), 1'($urandom_range(0, 2) == 0),
                       ADDR_W'($urandom_range(0, 63)), 32'($urandom));
         checkOutput("random");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
